rgb2gray_stream: RTL and testbench

Streaming RGB-to-grayscale converter feeding the `mean3x3` filter. It accepts one 24-bit RGB pixel per valid strobe in raster order and emits the BT.601 luma as an 8-bit `gray`/`gray_valid` stream. This stream plugs directly into `mean3x3.gray`/`gray_valid`. Alongside each output it provides raster coordinates and an end-of-frame pulse, so benches and downstream stages can index pixels without recounting.

---
 rtl/img_pkg.sv | 24 ++
 rtl/raster_counter.sv | 57 +++++
 rtl/rgb2gray_stream.sv | 153 +++++++++++++++
 tb/tb_rgb2gray_stream.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared pixel widths, BT.601 luma weights and coordinate type
//                for the grayscale / mean3x3 image pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int PIX_W      = 8;
    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;
    localparam int COORD_W    = 12;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } pix_coord_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Column/row wrap counter for raster-order pixel streams; the
//                outputs are the coordinate of the pixel accepted this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int COL_W        = 12,
    parameter int ROW_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

`default_nettype wire

// File: rtl/rgb2gray_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2gray_stream
//  Description : 3-stage streaming RGB -> BT.601 luma converter with raster
//                coordinates and end-of-frame flag. RGB2GRAY_ROUND_EN selects
//                round-half-up instead of truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb2gray_stream
    import img_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int COL_W        = 12,
    parameter int ROW_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rgb_valid,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    output logic             gray_valid,
    output logic [PIX_W-1:0] gray,
    output logic [ROW_W-1:0] gray_row,
    output logic [COL_W-1:0] gray_col,
    output logic             frame_done
);

    localparam int PROD_W = 2 * PIX_W;
`ifdef RGB2GRAY_ROUND_EN
    localparam logic [PROD_W-1:0] RND = PROD_W'(1 << (LUMA_SHIFT - 1));
`endif

    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             cur_last;

    raster_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .COL_W        (COL_W),
        .ROW_W        (ROW_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .advance (rgb_valid),
        .row     (cur_row),
        .col     (cur_col),
        .last    (cur_last)
    );

    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0] s1_pr_q, s1_pr_d, s1_pg_q, s1_pg_d, s1_pb_q, s1_pb_d;
    logic [ROW_W-1:0]  s1_row_q, s1_row_d;
    logic [COL_W-1:0]  s1_col_q, s1_col_d;
    logic              s1_last_q, s1_last_d;

    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] s2_sum_q, s2_sum_d;
    logic [ROW_W-1:0]  s2_row_q, s2_row_d;
    logic [COL_W-1:0]  s2_col_q, s2_col_d;
    logic              s2_last_q, s2_last_d;

    logic              gray_valid_q, gray_valid_d;
    logic [PIX_W-1:0]  gray_q, gray_d;
    logic [ROW_W-1:0]  gray_row_q, gray_row_d;
    logic [COL_W-1:0]  gray_col_q, gray_col_d;
    logic              frame_done_q, frame_done_d;

    always_comb begin
        // S1: weighted products; coordinates captured with the pixel
        s1_valid_d = rgb_valid;
        s1_pr_d    = PROD_W'(LUMA_R) * PROD_W'(r);
        s1_pg_d    = PROD_W'(LUMA_G) * PROD_W'(g);
        s1_pb_d    = PROD_W'(LUMA_B) * PROD_W'(b);
        s1_row_d   = cur_row;
        s1_col_d   = cur_col;
        s1_last_d  = cur_last;

        // S2: weights sum to 256, so the 16-bit sum (plus rounding) never overflows
        s2_valid_d = s1_valid_q;
`ifdef RGB2GRAY_ROUND_EN
        s2_sum_d   = s1_pr_q + s1_pg_q + s1_pb_q + RND;
`else
        s2_sum_d   = s1_pr_q + s1_pg_q + s1_pb_q;
`endif
        s2_row_d   = s1_row_q;
        s2_col_d   = s1_col_q;
        s2_last_d  = s1_last_q;

        // S3: data holds between pixels, frame_done only pulses with a pixel
        gray_valid_d = s2_valid_q;
        gray_d       = gray_q;
        gray_row_d   = gray_row_q;
        gray_col_d   = gray_col_q;
        frame_done_d = s2_valid_q & s2_last_q;
        if (s2_valid_q) begin
            gray_d     = s2_sum_q[LUMA_SHIFT +: PIX_W];
            gray_row_d = s2_row_q;
            gray_col_d = s2_col_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_pr_q      <= '0;
            s1_pg_q      <= '0;
            s1_pb_q      <= '0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_row_q     <= '0;
            s2_col_q     <= '0;
            s2_last_q    <= 1'b0;
            gray_valid_q <= 1'b0;
            gray_q       <= '0;
            gray_row_q   <= '0;
            gray_col_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_pr_q      <= s1_pr_d;
            s1_pg_q      <= s1_pg_d;
            s1_pb_q      <= s1_pb_d;
            s1_row_q     <= s1_row_d;
            s1_col_q     <= s1_col_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_q     <= s2_sum_d;
            s2_row_q     <= s2_row_d;
            s2_col_q     <= s2_col_d;
            s2_last_q    <= s2_last_d;
            gray_valid_q <= gray_valid_d;
            gray_q       <= gray_d;
            gray_row_q   <= gray_row_d;
            gray_col_q   <= gray_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign gray_valid = gray_valid_q;
    assign gray       = gray_q;
    assign gray_row   = gray_row_q;
    assign gray_col   = gray_col_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb2gray_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2gray_stream
//  Description : Self-checking bench for rgb2gray_stream (small frame size so a
//                full sparse frame fits in a short run).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2gray_stream;

    localparam int W  = 16;
    localparam int H  = 6;
    localparam int CW = 12;
    localparam int RW = 12;
`ifdef RGB2GRAY_ROUND_EN
    localparam int RND = 128;
    localparam bit ROUND = 1'b1;
`else
    localparam int RND = 0;
    localparam bit ROUND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rgb_valid = 1'b0;
    logic [7:0]    r = '0, g = '0, b = '0;
    logic          gray_valid;
    logic [7:0]    gray;
    logic [RW-1:0] gray_row;
    logic [CW-1:0] gray_col;
    logic          frame_done;

    rgb2gray_stream #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .COL_W        (CW),
        .ROW_W        (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rgb_valid  (rgb_valid),
        .r          (r),
        .g          (g),
        .b          (b),
        .gray_valid (gray_valid),
        .gray       (gray),
        .gray_row   (gray_row),
        .gray_col   (gray_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int gray;
        int row;
        int col;
        bit fd;
        int issue;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] r, g, b;
        int exp_rnd;
        int exp_trunc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int fd_cnt = 0;
    int mrow   = 0;
    int mcol   = 0;
    logic [7:0]    last_gray = '0;
    logic [RW-1:0] last_row  = '0;
    logic [CW-1:0] last_col  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int luma(input int rr, input int gg, input int bb);
        return (77 * rr + 150 * gg + 29 * bb + RND) / 256;
    endfunction

    // Drive one pixel; it stays on the bus until the next drive/idle call.
    task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                        input int eg);
        exp_t e;
        @(posedge clk);
        #1;
        r = rr; g = gg; b = bb;
        rgb_valid = 1'b1;
        e.gray  = eg;
        e.row   = mrow;
        e.col   = mcol;
        e.fd    = (mrow == H - 1) && (mcol == W - 1);
        e.issue = cyc;
        sb.push_back(e);
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rgb_valid = 1'b0;
        end
    endtask

    // Assert rst for n cycles; anything still in flight is dropped.
    task automatic do_reset(input int n, input bit hold_valid);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rgb_valid = hold_valid;
        r = 8'hff; g = 8'hff; b = 8'hff;
        @(negedge clk);
        #1;
        sb.delete();
        mrow = 0;
        mcol = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        rgb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (gray_valid === 1'b1) begin
            n_out++;
            if (frame_done === 1'b1) fd_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual gray=%0d row=%0d col=%0d required none",
                         gray, gray_row, gray_col);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("gray", 32'(gray), 32'(e.gray));
                chk("row", 32'(gray_row), 32'(e.row));
                chk("col", 32'(gray_col), 32'(e.col));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("latency", 32'(cyc - e.issue), 32'd3);
            end
            last_gray = gray;
            last_row  = gray_row;
            last_col  = gray_col;
        end else begin
            chk("frame_done_idle", 32'(frame_done), 32'd0);
            if (rst) begin
                last_gray = '0;
                last_row  = '0;
                last_col  = '0;
            end else begin
                chk("gray_hold", 32'(gray), 32'(last_gray));
                chk("row_hold", 32'(gray_row), 32'(last_row));
                chk("col_hold", 32'(gray_col), 32'(last_col));
            end
        end
    end

    initial begin
        vec_t tbl[8];
        int n0, f0;
        tbl[0] = '{8'd255, 8'd0,   8'd0,   77,  76};
        tbl[1] = '{8'd0,   8'd255, 8'd0,   149, 149};
        tbl[2] = '{8'd0,   8'd0,   8'd255, 29,  28};
        tbl[3] = '{8'd100, 8'd100, 8'd100, 100, 100};
        tbl[4] = '{8'd1,   8'd1,   8'd1,   1,   1};
        tbl[5] = '{8'd0,   8'd0,   8'd0,   0,   0};
        tbl[6] = '{8'd128, 8'd64,  8'd32,  80,  79};
        tbl[7] = '{8'd10,  8'd200, 8'd50,  126, 125};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gray_valid", 32'(gray_valid), 32'd0);
        chk("rst_gray", 32'(gray), 32'd0);
        chk("rst_row", 32'(gray_row), 32'd0);
        chk("rst_col", 32'(gray_col), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single white pixel at (0,0)
        send(8'd255, 8'd255, 8'd255, 255);
        idle(6);

        // Back-to-back table vectors
        for (int i = 0; i < 8; i++)
            send(tbl[i].r, tbl[i].g, tbl[i].b, ROUND ? tbl[i].exp_rnd : tbl[i].exp_trunc);
        idle(6);

        // Full frame, one valid every 11 cycles, then the wrap pixel (0,0)
        do_reset(1, 1'b0);
        n0 = n_out;
        f0 = fd_cnt;
        for (int i = 0; i < W * H; i++) begin
            logic [7:0] pr, pg, pb;
            pr = 8'($urandom_range(0, 255));
            pg = 8'($urandom_range(0, 255));
            pb = 8'($urandom_range(0, 255));
            send(pr, pg, pb, luma(pr, pg, pb));
            idle(10);
        end
        chk("frame_outputs", 32'(n_out - n0), 32'(W * H));
        chk("frame_done_count", 32'(fd_cnt - f0), 32'd1);
        send(8'd20, 8'd40, 8'd60, luma(20, 40, 60));
        idle(6);

        // Reset with two pixels in flight mid-row 5
        for (int i = 0; i < 200 && !(mrow == 5 && mcol == 6); i++)
            send(8'(i), 8'(3 * i), 8'(7 * i), luma(i % 256, (3 * i) % 256, (7 * i) % 256));
        idle(6);
        n0 = n_out;
        send(8'd50, 8'd60, 8'd70, luma(50, 60, 70));
        send(8'd80, 8'd90, 8'd99, luma(80, 90, 99));
        do_reset(1, 1'b0);
        idle(8);
        chk("inflight_dropped", 32'(n_out - n0), 32'd0);
        send(8'd255, 8'd255, 8'd255, 255);
        idle(6);

        // rgb_valid held high during a 3-cycle reset
        n0 = n_out;
        do_reset(3, 1'b1);
        idle(8);
        chk("valid_during_rst", 32'(n_out - n0), 32'd0);
        send(8'd100, 8'd100, 8'd100, 100);
        idle(1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
